wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Sits between the functional units (ALU, LSU, BR) and writeback_module.
- Buffers each FU's completed wb_packet_t in a small per-port queue and selects one packet per cycle into a registered output slot that drives the writeback stage.
- Branch results get strict priority so mispredict recovery starts as early as possible.
- On a recovery event, queued packets younger than the mispredicted branch are squashed.

Parameters:
- ROB_DEPTH, 16, ROB entries; age arithmetic uses ROB_PTR_W = $clog2(ROB_DEPTH) bits.
- QDEPTH, 2, entries per FU queue; power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- alu_valid_i  in  1  ALU result valid
- alu_packet_i  in  wb_packet_t  ALU result
- alu_ready_o  out  1  ALU queue not full
- lsu_valid_i / lsu_packet_i / lsu_ready_o  as ALU, for LSU
- br_valid_i / br_packet_i / br_ready_o  as ALU, for BR
- wb_valid_o  out  1  output slot holds a packet
- wb_packet_o  out  wb_packet_t  packet to writeback_module
- wb_ready_i  in  1  writeback accepts the packet
- recover_i  in  1  mispredict recovery pulse from writeback
- recover_rob_tag_i  in  4  ROB tag of the mispredicted branch
- rob_head_i  in  ROB_PTR_W  current ROB head index, used as the age reference

Behaviour:
- Reset:
  - All queues empty; output slot empty; wb_valid_o=0; wb_packet_o='0.
  - All *_ready_o=1 from the first cycle after reset.
  - Round-robin pointer points to ALU.
- Enqueue:
  - *_ready_o = (queue count < QDEPTH). It depends on registered count only; there is no combinational path from wb_ready_i.
  - A packet enqueues on valid&ready.
  - On enqueue, the arbiter overwrites src_fu: ALU=0, LSU=1, BR=2.
- Output slot:
  - Registered.
  - Loads when it is empty, or when it is full and wb_ready_i=1 in the same cycle (back-to-back throughput of 1 per cycle).
  - Latency from FU handshake to wb_valid_o is at least 1 cycle.
  - Contents hold stable while wb_valid_o & !wb_ready_i.
- Selection, among non-empty queues whose head is live:
  - BR always wins.
  - Otherwise ALU and LSU round-robin. The pointer toggles to the other port only when the current one is granted.
- Queues:
  - Circular, with head/tail pointers wrapping at QDEPTH.
  - Same-cycle enqueue and dequeue on a full queue is not allowed, because ready is based on count.
- Age:
  - age(t) = (t[ROB_PTR_W-1:0] - rob_head_i) mod ROB_DEPTH.
  - A packet is younger than the branch iff age(tag) > age(recover_rob_tag_i).
  - The branch packet itself (equal age) is never squashed.
- Recovery (cycle where recover_i=1):
  - Every queued entry younger than the branch has its live bit cleared.
  - A full output slot holding a younger packet is emptied next cycle; wb_valid_o drops.
  - Incoming packets handshaked that same cycle are enqueued with live=0 if younger.
  - Selection in the recover_i cycle uses post-squash liveness: no younger packet is loaded into the slot.
- Dead heads: a queue head with live=0 is popped in one cycle without using the output slot. This may happen in parallel with a live grant from another queue.
- Simultaneous events: enqueue, dead pop and grant on different queues all occur in the same cycle. Enqueue plus grant on the same non-full queue leaves count unchanged.
- Reset mid-operation: all queued and in-flight packets are discarded with no output pulse.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- With the macro defined, the block adds outputs stat_alu_stall_o, stat_lsu_stall_o, stat_br_stall_o and stat_squash_o (32 bits each, reset 0, saturating):
  - Each stall counter increments every cycle its port has valid=1 and ready=0.
  - stat_squash_o increments once per packet squashed.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset, then an ALU packet with ROB_tag=3, rd_addr=5, rd_val=0xDEAD in cycle 1, wb_ready_i=1 -> wb_valid_o=1 in cycle 2 with src_fu=0, ROB_tag=3, rd_val=0xDEAD; then wb_valid_o=0 in cycle 3.
2. ALU (tag 1), LSU (tag 2) and BR (tag 4) valid in the same cycle, then ALU tag 5 and LSU tag 6 -> output order is BR4, ALU1, LSU2, ALU5, LSU6.
3. wb_ready_i=0 for 4 cycles while ALU pushes tags 1,2,3 -> alu_ready_o=0 after 2 queued plus 1 in the slot; the slot holds tag 1 stable; after release, tags 1,2,3 appear in order with no loss.
4. rob_head_i=14, LSU queue holds tags 15 and 1, slot holds tag 0, recover_i=1 with recover_rob_tag_i=15 -> tag 1 dropped, tag 0 dropped from the slot, tag 15 issued next.
5. rob_head_i=0, recover_i=1 with tag 2 in the same cycle as an ALU handshake for tag 3 and a BR handshake for tag 2 -> the BR packet with tag 2 is issued; the ALU packet with tag 3 never appears on wb_valid_o.
6. rst_i asserted while 3 packets are buffered -> next cycle wb_valid_o=0 and all ready=1; no stale packets appear afterward.

Source files
------------

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
//
// Purpose:
//   Collects completed results from the ALU, LSU and BR functional units and
//   feeds them one per cycle into writeback_module. Each unit has a small
//   circular queue. A registered output slot drives the writeback stage.
//   Branch results always take priority. ALU and LSU share the remaining
//   slots in round-robin order. When a mispredict recovery pulse arrives,
//   every packet younger than the mispredicted branch is squashed. This
//   covers packets in the queues, in the output slot, and packets arriving
//   in the same cycle.
//
// Handshake (all ports):
//   A transfer happens on a rising clk edge when valid and ready are both 1.
//   The producer holds valid and the payload stable until that edge. Ready
//   never depends combinationally on the valid of the same interface.
//   *_ready_o is taken only from registered queue occupancy.
//   wb_valid_o and wb_packet_o are taken only from the registered output
//   slot.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   alu_valid_i/_packet_i/_ready_o  ALU result input
//   lsu_valid_i/_packet_i/_ready_o  LSU result input
//   br_valid_i/_packet_i/_ready_o   BR result input
//   wb_valid_o, wb_packet_o       registered output slot towards writeback
//   wb_ready_i                    writeback accepts the slot contents
//   recover_i, recover_rob_tag_i  mispredict recovery pulse and branch tag
//   rob_head_i                    ROB head index; this is the age reference
//
// Optional build macro:
//   WB_ARB_STATS_EN adds the following saturating 32-bit counters:
//   stat_alu_stall_o, stat_lsu_stall_o, stat_br_stall_o, stat_squash_o.
//
// ROB_DEPTH and QDEPTH must be powers of two. Pointer and age arithmetic
// rely on natural wrap-around of the counters.
// ----------------------------------------------------------------------------

package wb_arbiter_pkg;

    typedef struct packed {
        logic [1:0]  src_fu;     // overwritten by the arbiter on enqueue
        logic [3:0]  rob_tag;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_val;
        logic        mispredict;
    } wb_packet_t;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_LSU = 2'd1;
    localparam logic [1:0] FU_BR  = 2'd2;

endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int ROB_DEPTH = 16,
    parameter  int QDEPTH    = 2,
    localparam int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 alu_valid_i,
    input  wb_packet_t           alu_packet_i,
    output logic                 alu_ready_o,

    input  logic                 lsu_valid_i,
    input  wb_packet_t           lsu_packet_i,
    output logic                 lsu_ready_o,

    input  logic                 br_valid_i,
    input  wb_packet_t           br_packet_i,
    output logic                 br_ready_o,

    output logic                 wb_valid_o,
    output wb_packet_t           wb_packet_o,
    input  logic                 wb_ready_i,

    input  logic                 recover_i,
    input  logic [3:0]           recover_rob_tag_i,
    input  logic [ROB_PTR_W-1:0] rob_head_i
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]          stat_alu_stall_o,
    output logic [31:0]          stat_lsu_stall_o,
    output logic [31:0]          stat_br_stall_o,
    output logic [31:0]          stat_squash_o
`endif
);

    localparam int NP     = 3;
    localparam int P_ALU  = 0;
    localparam int P_LSU  = 1;
    localparam int P_BR   = 2;
    localparam int QPTR_W = $clog2(QDEPTH);
    localparam int CNT_W  = QPTR_W + 1;

    // ------------------------------------------------------------------
    // Age helpers: the distance from the ROB head, wrapping at ROB_DEPTH.
    // ------------------------------------------------------------------
    function automatic logic [ROB_PTR_W-1:0] age_of(
        input logic [3:0]           tag,
        input logic [ROB_PTR_W-1:0] head
    );
        return ROB_PTR_W'(tag) - head;
    endfunction

    function automatic logic is_young(
        input logic [3:0]           tag,
        input logic                 rec,
        input logic [ROB_PTR_W-1:0] head,
        input logic [ROB_PTR_W-1:0] rage
    );
        return rec && (age_of(tag, head) > rage);
    endfunction

    // ------------------------------------------------------------------
    // Per-port input views, indexed ALU=0, LSU=1, BR=2. The index also
    // serves as the src_fu encoding.
    // ------------------------------------------------------------------
    logic [NP-1:0] in_valid;
    wb_packet_t    in_pkt [NP];

    assign in_valid      = {br_valid_i, lsu_valid_i, alu_valid_i};
    assign in_pkt[P_ALU] = alu_packet_i;
    assign in_pkt[P_LSU] = lsu_packet_i;
    assign in_pkt[P_BR]  = br_packet_i;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wb_packet_t        mem_q   [NP][QDEPTH];
    logic [QDEPTH-1:0] live_q  [NP];
    logic [QPTR_W-1:0] head_q  [NP];
    logic [QPTR_W-1:0] tail_q  [NP];
    logic [CNT_W-1:0]  count_q [NP];
    logic [CNT_W-1:0]  count_d [NP];

    logic              rr_q, rr_d;          // 0: ALU's turn, 1: LSU's turn
    logic              slot_valid_q, slot_valid_d;
    wb_packet_t        slot_pkt_q, slot_pkt_d;

    // ------------------------------------------------------------------
    // Combinational selection
    // ------------------------------------------------------------------
    logic [ROB_PTR_W-1:0] rec_age;
    logic [NP-1:0]        ready, enq, nonempty, head_live, head_dead;
    logic [NP-1:0]        in_young, bypass, cand, grant, pop, store;
    wb_packet_t           head_pkt  [NP];
    wb_packet_t           tagged_in [NP];
    wb_packet_t           cand_pkt  [NP];
    logic                 slot_load_en;
    logic                 slot_young;

    assign rec_age = age_of(recover_rob_tag_i, rob_head_i);

    always_comb begin
        ready        = '0;
        enq          = '0;
        nonempty     = '0;
        head_live    = '0;
        head_dead    = '0;
        in_young     = '0;
        bypass       = '0;
        cand         = '0;
        grant        = '0;
        pop          = '0;
        store        = '0;
        rr_d         = rr_q;
        slot_valid_d = slot_valid_q;
        slot_pkt_d   = slot_pkt_q;

        for (int p = 0; p < NP; p++) begin
            head_pkt[p]         = mem_q[p][head_q[p]];
            tagged_in[p]        = in_pkt[p];
            tagged_in[p].src_fu = 2'(p);
            nonempty[p]         = (count_q[p] != '0);
            ready[p]            = (count_q[p] < CNT_W'(QDEPTH));
            enq[p]              = in_valid[p] & ready[p];
            in_young[p]         = is_young(in_pkt[p].rob_tag, recover_i,
                                           rob_head_i, rec_age);
            // Liveness is evaluated after this cycle's squash. A packet
            // that is being killed now can therefore never be selected.
            head_live[p]        = nonempty[p] & live_q[p][head_q[p]] &
                                  ~is_young(head_pkt[p].rob_tag, recover_i,
                                            rob_head_i, rec_age);
            head_dead[p]        = nonempty[p] & ~head_live[p];
            // An empty queue lets the arriving packet compete directly.
            // This gives a single cycle of latency from handshake to output.
            bypass[p]           = ~nonempty[p] & in_valid[p] & ~in_young[p];
            cand[p]             = head_live[p] | bypass[p];
            cand_pkt[p]         = nonempty[p] ? head_pkt[p] : tagged_in[p];
        end

        slot_load_en = ~slot_valid_q | wb_ready_i;

        if (slot_load_en) begin
            if (cand[P_BR]) begin
                grant[P_BR] = 1'b1;
            end else if (!rr_q) begin
                if (cand[P_ALU])      grant[P_ALU] = 1'b1;
                else if (cand[P_LSU]) grant[P_LSU] = 1'b1;
            end else begin
                if (cand[P_LSU])      grant[P_LSU] = 1'b1;
                else if (cand[P_ALU]) grant[P_ALU] = 1'b1;
            end
        end

        // The turn passes only when the port that holds it is served.
        if (!rr_q && grant[P_ALU])     rr_d = 1'b1;
        else if (rr_q && grant[P_LSU]) rr_d = 1'b0;

        for (int p = 0; p < NP; p++) begin
            // A dead head leaves in one cycle without touching the slot.
            pop[p]     = (grant[p] & nonempty[p]) | head_dead[p];
            // A bypassed packet goes straight to the slot and is never stored.
            store[p]   = enq[p] & ~(grant[p] & ~nonempty[p]);
            count_d[p] = count_q[p] + CNT_W'(store[p]) - CNT_W'(pop[p]);
        end

        slot_young = is_young(slot_pkt_q.rob_tag, recover_i, rob_head_i,
                              rec_age);

        if (slot_load_en) begin
            slot_valid_d = |grant;
            if (grant[P_BR])       slot_pkt_d = cand_pkt[P_BR];
            else if (grant[P_ALU]) slot_pkt_d = cand_pkt[P_ALU];
            else if (grant[P_LSU]) slot_pkt_d = cand_pkt[P_LSU];
        end else if (slot_young) begin
            // A held packet that is younger than the branch is dropped.
            // Its contents stay in place but are no longer valid.
            slot_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NP; p++) begin
                head_q[p]  <= '0;
                tail_q[p]  <= '0;
                count_q[p] <= '0;
                live_q[p]  <= '0;
            end
            rr_q         <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_pkt_q   <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                for (int e = 0; e < QDEPTH; e++) begin
                    if (is_young(mem_q[p][e].rob_tag, recover_i, rob_head_i,
                                 rec_age)) begin
                        live_q[p][e] <= 1'b0;
                    end
                end
                // The tail slot is always free when storing, because ready
                // is taken from the count. The write below therefore never
                // collides with an occupied entry.
                if (store[p]) begin
                    mem_q[p][tail_q[p]]  <= tagged_in[p];
                    live_q[p][tail_q[p]] <= ~in_young[p];
                    tail_q[p]            <= tail_q[p] + QPTR_W'(1);
                end
                if (pop[p]) begin
                    head_q[p] <= head_q[p] + QPTR_W'(1);
                end
                count_q[p] <= count_d[p];
            end
            rr_q         <= rr_d;
            slot_valid_q <= slot_valid_d;
            slot_pkt_q   <= slot_pkt_d;
        end
    end

    assign alu_ready_o = ready[P_ALU];
    assign lsu_ready_o = ready[P_LSU];
    assign br_ready_o  = ready[P_BR];
    assign wb_valid_o  = slot_valid_q;
    assign wb_packet_o = slot_pkt_q;

`ifdef WB_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (saturating)
    // ------------------------------------------------------------------
    localparam int SQ_W = $clog2(NP * QDEPTH + NP + 2) + 1;

    logic [31:0]       stall_q [NP];
    logic [31:0]       squash_q;
    logic [SQ_W-1:0]   squash_inc;
    logic [QPTR_W-1:0] sq_offs;
    logic [32:0]       squash_sum;

    // Each packet is counted once, at the moment its live bit goes from 1
    // to 0. Packets that are already dead are not counted again. A slot
    // packet that writeback accepts in this same cycle counts as delivered,
    // not squashed.
    always_comb begin
        squash_inc = '0;
        sq_offs    = '0;
        for (int p = 0; p < NP; p++) begin
            for (int e = 0; e < QDEPTH; e++) begin
                sq_offs = QPTR_W'(e) - head_q[p];
                if ((CNT_W'(sq_offs) < count_q[p]) && live_q[p][e] &&
                    is_young(mem_q[p][e].rob_tag, recover_i, rob_head_i,
                             rec_age)) begin
                    squash_inc = squash_inc + SQ_W'(1);
                end
            end
            if (store[p] && in_young[p]) begin
                squash_inc = squash_inc + SQ_W'(1);
            end
        end
        if (slot_valid_q && !wb_ready_i && slot_young) begin
            squash_inc = squash_inc + SQ_W'(1);
        end
        squash_sum = {1'b0, squash_q} + 33'(squash_inc);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NP; p++) stall_q[p] <= '0;
            squash_q <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (in_valid[p] && !ready[p] && (stall_q[p] != '1)) begin
                    stall_q[p] <= stall_q[p] + 32'd1;
                end
            end
            squash_q <= squash_sum[32] ? '1 : squash_sum[31:0];
        end
    end

    assign stat_alu_stall_o = stall_q[P_ALU];
    assign stat_lsu_stall_o = stall_q[P_LSU];
    assign stat_br_stall_o  = stall_q[P_BR];
    assign stat_squash_o    = squash_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter. It runs directed scenarios with
// constant expectations, followed by a randomized run. The randomized run
// is compared every cycle against a queue-based reference model. In that
// model each unit's queue is a view of one arrival-ordered list, filtered
// by port.
// ----------------------------------------------------------------------------

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int ROB_DEPTH = 16;
    localparam int QDEPTH    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i;
    logic       alu_valid_i, lsu_valid_i, br_valid_i;
    wb_packet_t alu_packet_i, lsu_packet_i, br_packet_i;
    logic       alu_ready_o, lsu_ready_o, br_ready_o;
    logic       wb_valid_o;
    wb_packet_t wb_packet_o;
    logic       wb_ready_i;
    logic       recover_i;
    logic [3:0] recover_rob_tag_i;
    logic [3:0] rob_head_i;

    wb_arbiter #(.ROB_DEPTH(ROB_DEPTH), .QDEPTH(QDEPTH)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .alu_valid_i       (alu_valid_i),
        .alu_packet_i      (alu_packet_i),
        .alu_ready_o       (alu_ready_o),
        .lsu_valid_i       (lsu_valid_i),
        .lsu_packet_i      (lsu_packet_i),
        .lsu_ready_o       (lsu_ready_o),
        .br_valid_i        (br_valid_i),
        .br_packet_i       (br_packet_i),
        .br_ready_o        (br_ready_o),
        .wb_valid_o        (wb_valid_o),
        .wb_packet_o       (wb_packet_o),
        .wb_ready_i        (wb_ready_i),
        .recover_i         (recover_i),
        .recover_rob_tag_i (recover_rob_tag_i),
        .rob_head_i        (rob_head_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        wb_packet_t pkt;
        int         port;
        bit         live;
    } ment_t;

    ment_t      mq[$];       // every buffered packet, in arrival order
    bit         m_slot_v;
    wb_packet_t m_slot;
    int         m_rr;        // 0: ALU's turn, 1: LSU's turn

    function automatic int age(int t, int h);
        return (((t - h) % ROB_DEPTH) + ROB_DEPTH) % ROB_DEPTH;
    endfunction

    function automatic bit younger(logic [3:0] t);
        return recover_i &&
               (age(int'(t), int'(rob_head_i)) >
                age(int'(recover_rob_tag_i), int'(rob_head_i)));
    endfunction

    function automatic int port_count(int p);
        int n = 0;
        foreach (mq[i]) if (mq[i].port == p) n++;
        return n;
    endfunction

    function automatic int port_head(int p);
        foreach (mq[i]) if (mq[i].port == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_slot_v = 1'b0;
        m_slot   = '0;
        m_rr     = 0;
    endtask

    task automatic model_step();
        bit         vin[3];
        wb_packet_t pin[3];
        bit         rdy[3];
        int         hd[3];
        bit         cand[3];
        bit         rm[3];
        int         g;
        bit         load_en;
        bit         drop;
        ment_t      keep[$];
        ment_t      e;
        vin[0] = alu_valid_i;  vin[1] = lsu_valid_i;  vin[2] = br_valid_i;
        pin[0] = alu_packet_i; pin[1] = lsu_packet_i; pin[2] = br_packet_i;
        for (int p = 0; p < 3; p++) rdy[p] = (port_count(p) < QDEPTH);
        if (recover_i)
            foreach (mq[i]) if (younger(mq[i].pkt.rob_tag)) mq[i].live = 1'b0;
        load_en = !m_slot_v || wb_ready_i;
        if (!load_en && m_slot_v && younger(m_slot.rob_tag)) m_slot_v = 1'b0;
        for (int p = 0; p < 3; p++) begin
            hd[p] = port_head(p);
            if (hd[p] >= 0) cand[p] = mq[hd[p]].live;
            else            cand[p] = vin[p] && !younger(pin[p].rob_tag);
        end
        g = -1;
        if (load_en) begin
            if (cand[2])             g = 2;
            else if (cand[m_rr])     g = m_rr;
            else if (cand[1 - m_rr]) g = 1 - m_rr;
        end
        if (load_en) begin
            if (g >= 0) begin
                m_slot_v = 1'b1;
                if (hd[g] >= 0) m_slot = mq[hd[g]].pkt;
                else begin
                    m_slot        = pin[g];
                    m_slot.src_fu = 2'(g);
                end
            end else begin
                m_slot_v = 1'b0;
            end
        end
        if (g == m_rr) m_rr = 1 - m_rr;
        for (int p = 0; p < 3; p++)
            rm[p] = (hd[p] >= 0) && (!mq[hd[p]].live || g == p);
        for (int i = 0; i < mq.size(); i++) begin
            drop = 1'b0;
            for (int p = 0; p < 3; p++) if (rm[p] && hd[p] == i) drop = 1'b1;
            if (!drop) keep.push_back(mq[i]);
        end
        mq = keep;
        for (int p = 0; p < 3; p++) begin
            if (vin[p] && rdy[p] && !(g == p && hd[p] < 0)) begin
                e.pkt        = pin[p];
                e.pkt.src_fu = 2'(p);
                e.port       = p;
                e.live       = !younger(pin[p].rob_tag);
                mq.push_back(e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        if (rst_i) model_reset();
        else       model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_packet_t mk_pkt(int tag, int rd, logic [31:0] val);
        wb_packet_t p;
        p            = '0;
        p.src_fu     = 2'd3;         // garbage; the arbiter must overwrite it
        p.rob_tag    = 4'(tag);
        p.rd_we      = 1'b1;
        p.rd_addr    = 5'(rd);
        p.rd_val     = val;
        return p;
    endfunction

    task automatic clear_inputs();
        alu_valid_i = 0; lsu_valid_i = 0; br_valid_i = 0;
        alu_packet_i = '0; lsu_packet_i = '0; br_packet_i = '0;
        recover_i = 0; recover_rob_tag_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rob_head_i = '0;
        wb_ready_i = 1'b1;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", wb_valid_o);
        end
        n_tests++;
        if (wb_packet_o !== '0) begin
            n_fail++; $display("FAIL reset_packet: got %h want 0", wb_packet_o);
        end
        n_tests++;
        if ({alu_ready_o, lsu_ready_o, br_ready_o} !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready: got %b want 111",
                               {alu_ready_o, lsu_ready_o, br_ready_o});
        end
    endtask

    task automatic test_single();
        do_reset();
        alu_valid_i = 1; alu_packet_i = mk_pkt(3, 5, 32'hDEAD);
        tick();
        alu_valid_i = 0;
        n_tests++;
        if (wb_valid_o !== 1'b1 || wb_packet_o.src_fu !== 2'd0 ||
            wb_packet_o.rob_tag !== 4'd3 || wb_packet_o.rd_addr !== 5'd5 ||
            wb_packet_o.rd_val !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL single_out: got v=%b src=%0d tag=%0d rd=%0d val=%h want v=1 src=0 tag=3 rd=5 val=dead",
                     wb_valid_o, wb_packet_o.src_fu, wb_packet_o.rob_tag,
                     wb_packet_o.rd_addr, wb_packet_o.rd_val);
        end
        tick();
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_drop: got %b want 0", wb_valid_o);
        end
    endtask

    task automatic test_priority();
        int exp_tag[5] = '{4, 1, 2, 5, 6};
        int exp_src[5] = '{2, 0, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            if (k == 0) begin
                alu_valid_i = 1; alu_packet_i = mk_pkt(1, 1, 32'h11);
                lsu_valid_i = 1; lsu_packet_i = mk_pkt(2, 2, 32'h22);
                br_valid_i  = 1; br_packet_i  = mk_pkt(4, 0, 32'h44);
            end else if (k == 1) begin
                alu_valid_i = 1; alu_packet_i = mk_pkt(5, 3, 32'h55);
                lsu_valid_i = 1; lsu_packet_i = mk_pkt(6, 4, 32'h66);
            end
            tick();
            n_tests++;
            if (k < 5) begin
                if (wb_valid_o !== 1'b1 || wb_packet_o.rob_tag !== 4'(exp_tag[k]) ||
                    wb_packet_o.src_fu !== 2'(exp_src[k])) begin
                    n_fail++;
                    $display("FAIL priority_order[%0d]: got v=%b tag=%0d src=%0d want tag=%0d src=%0d",
                             k, wb_valid_o, wb_packet_o.rob_tag, wb_packet_o.src_fu,
                             exp_tag[k], exp_src[k]);
                end
            end else if (wb_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL priority_idle: got %b want 0", wb_valid_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            if (k < 3) begin
                alu_valid_i = 1; alu_packet_i = mk_pkt(k + 1, k, 32'(k + 100));
            end
            tick();
            n_tests++;
            if (wb_valid_o !== 1'b1 || wb_packet_o.rob_tag !== 4'd1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b tag=%0d want v=1 tag=1",
                                   k, wb_valid_o, wb_packet_o.rob_tag);
            end
            if (k >= 2) begin
                n_tests++;
                if (alu_ready_o !== 1'b0) begin
                    n_fail++; $display("FAIL bp_full[%0d]: got %b want 0", k, alu_ready_o);
                end
            end
        end
        clear_inputs();
        wb_ready_i = 1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            n_tests++;
            if (k <= 3) begin
                if (wb_valid_o !== 1'b1 || wb_packet_o.rob_tag !== 4'(k)) begin
                    n_fail++; $display("FAIL bp_drain[%0d]: got v=%b tag=%0d want tag=%0d",
                                       k, wb_valid_o, wb_packet_o.rob_tag, k);
                end
            end else if (wb_valid_o !== 1'b0 || alu_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL bp_end: got v=%b rdy=%b want v=0 rdy=1",
                                   wb_valid_o, alu_ready_o);
            end
        end
    endtask

    task automatic test_recover_queue();
        int tags[3] = '{0, 15, 1};
        do_reset();
        rob_head_i = 4'd14;
        wb_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            lsu_valid_i = 1; lsu_packet_i = mk_pkt(tags[k], 7, 32'(tags[k]));
            tick();
        end
        clear_inputs();
        n_tests++;
        if (wb_valid_o !== 1'b1 || wb_packet_o.rob_tag !== 4'd0) begin
            n_fail++; $display("FAIL rq_setup: got v=%b tag=%0d want v=1 tag=0",
                               wb_valid_o, wb_packet_o.rob_tag);
        end
        recover_i = 1; recover_rob_tag_i = 4'd15;
        tick();
        clear_inputs();
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rq_slot_squash: got %b want 0", wb_valid_o);
        end
        tick();
        n_tests++;
        if (wb_valid_o !== 1'b1 || wb_packet_o.rob_tag !== 4'd15 ||
            wb_packet_o.src_fu !== 2'd1) begin
            n_fail++; $display("FAIL rq_issue15: got v=%b tag=%0d src=%0d want v=1 tag=15 src=1",
                               wb_valid_o, wb_packet_o.rob_tag, wb_packet_o.src_fu);
        end
        wb_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (wb_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rq_no_tag1[%0d]: got v=%b tag=%0d want v=0",
                                   k, wb_valid_o, wb_packet_o.rob_tag);
            end
        end
        n_tests++;
        if (lsu_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rq_drained: got %b want 1", lsu_ready_o);
        end
    endtask

    task automatic test_recover_same_cycle();
        do_reset();
        rob_head_i = 4'd0;
        recover_i = 1; recover_rob_tag_i = 4'd2;
        alu_valid_i = 1; alu_packet_i = mk_pkt(3, 9, 32'h333);
        br_valid_i  = 1; br_packet_i  = mk_pkt(2, 0, 32'h222);
        tick();
        clear_inputs();
        n_tests++;
        if (wb_valid_o !== 1'b1 || wb_packet_o.rob_tag !== 4'd2 ||
            wb_packet_o.src_fu !== 2'd2) begin
            n_fail++; $display("FAIL rs_branch: got v=%b tag=%0d src=%0d want v=1 tag=2 src=2",
                               wb_valid_o, wb_packet_o.rob_tag, wb_packet_o.src_fu);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (wb_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rs_no_alu[%0d]: got v=%b tag=%0d want v=0",
                                   k, wb_valid_o, wb_packet_o.rob_tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_ready_i = 0;
        alu_valid_i = 1; alu_packet_i = mk_pkt(7, 1, 32'h7);
        lsu_valid_i = 1; lsu_packet_i = mk_pkt(8, 2, 32'h8);
        br_valid_i  = 1; br_packet_i  = mk_pkt(9, 3, 32'h9);
        tick();
        clear_inputs();
        n_tests++;
        if (wb_valid_o !== 1'b1 || wb_packet_o.rob_tag !== 4'd9) begin
            n_fail++; $display("FAIL rm_setup: got v=%b tag=%0d want v=1 tag=9",
                               wb_valid_o, wb_packet_o.rob_tag);
        end
        rst_i = 1;
        tick();
        rst_i = 0;
        n_tests++;
        if (wb_valid_o !== 1'b0 || wb_packet_o !== '0 ||
            {alu_ready_o, lsu_ready_o, br_ready_o} !== 3'b111) begin
            n_fail++; $display("FAIL rm_after_reset: got v=%b pkt=%h rdy=%b want v=0 pkt=0 rdy=111",
                               wb_valid_o, wb_packet_o, {alu_ready_o, lsu_ready_o, br_ready_o});
        end
        wb_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (wb_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rm_stale[%0d]: got v=%b tag=%0d want v=0",
                                   k, wb_valid_o, wb_packet_o.rob_tag);
            end
        end
    endtask

    task automatic test_random();
        int prints = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_i       = ($urandom_range(0, 499) == 0);
            alu_valid_i = ($urandom_range(0, 9) < 6);
            lsu_valid_i = ($urandom_range(0, 9) < 5);
            br_valid_i  = ($urandom_range(0, 9) < 3);
            alu_packet_i = mk_pkt($urandom_range(0, 15), $urandom_range(0, 31), $urandom);
            lsu_packet_i = mk_pkt($urandom_range(0, 15), $urandom_range(0, 31), $urandom);
            br_packet_i  = mk_pkt($urandom_range(0, 15), $urandom_range(0, 31), $urandom);
            wb_ready_i  = ($urandom_range(0, 9) < 7);
            recover_i   = ($urandom_range(0, 11) == 0);
            recover_rob_tag_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rob_head_i = 4'($urandom_range(0, 15));
            tick();
            n_tests++;
            if (wb_valid_o !== m_slot_v ||
                (m_slot_v && wb_packet_o !== m_slot) ||
                alu_ready_o !== (port_count(0) < QDEPTH) ||
                lsu_ready_o !== (port_count(1) < QDEPTH) ||
                br_ready_o  !== (port_count(2) < QDEPTH)) begin
                n_fail++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL random[%0d]: got v=%b pkt=%h rdy=%b%b%b want v=%b pkt=%h rdy=%b%b%b",
                             c, wb_valid_o, wb_packet_o, alu_ready_o, lsu_ready_o, br_ready_o,
                             m_slot_v, m_slot, port_count(0) < QDEPTH,
                             port_count(1) < QDEPTH, port_count(2) < QDEPTH);
                end
            end
        end
        rst_i = 0;
        clear_inputs();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- main sequence / report ----------------
    initial begin
        clear_inputs();
        rst_i = 1; wb_ready_i = 1; rob_head_i = '0;
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_recover_queue();
        test_recover_same_cycle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
